mem_rr_arbiter: RTL

MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

---
 rtl/mem_rr_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: shares one memory read/write channel among NUM_CONSUMERS
// requesters. Grants go round-robin from a rotating priority pointer, and at
// most one memory transaction is outstanding at a time. A consumer that
// asserts read and write together is served the read first. Its write stays
// pending for a later grant.
//
// Ports
//   clk, reset                      clock; asynchronous active-low reset
//   consumer_read_valid/address     per-consumer read request (in)
//   consumer_read_ready/data        per-consumer read response (out)
//   consumer_write_valid/address/data  per-consumer write request (in)
//   consumer_write_ready            per-consumer write completion (out)
//   mem_read_valid/address          read request to memory (out)
//   mem_read_ready/data             read response from memory (in)
//   mem_write_valid/address/data    write request to memory (out)
//   mem_write_ready                 write acknowledge from memory (in)
//   busy                            high whenever a transaction is in flight
//   grant_id                        index of the consumer currently served
module mem_rr_arbiter #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned IDX_BITS      = $clog2(NUM_CONSUMERS)
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address  [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data     [NUM_CONSUMERS],

    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,

    output logic                     mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address,
    input  logic                     mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data,

    output logic                     mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address,
    output logic [DATA_BITS-1:0]     mem_write_data,
    input  logic                     mem_write_ready,

    output logic                     busy,
    output logic [IDX_BITS-1:0]      grant_id
);

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } state_t;

    state_t                   state;
    state_t                   state_d;
    logic [IDX_BITS-1:0]      rr_ptr;
    logic [IDX_BITS-1:0]      rr_ptr_d;

    logic [IDX_BITS-1:0]      grant_id_d;
    logic                     busy_d;
    logic                     mem_read_valid_d;
    logic [ADDR_BITS-1:0]     mem_read_address_d;
    logic                     mem_write_valid_d;
    logic [ADDR_BITS-1:0]     mem_write_address_d;
    logic [DATA_BITS-1:0]     mem_write_data_d;
    logic [NUM_CONSUMERS-1:0] read_ready_d;
    logic [NUM_CONSUMERS-1:0] write_ready_d;
    logic [DATA_BITS-1:0]     read_data_d [NUM_CONSUMERS];

    logic                     scan_found;
    logic [IDX_BITS-1:0]      scan_idx;
    logic [IDX_BITS-1:0]      scan_cand;

    // Round-robin scan: first requester at or after rr_ptr. The candidate
    // index wraps naturally because NUM_CONSUMERS is a power of two.
    always_comb begin : rr_scan
        scan_found = 1'b0;
        scan_idx   = rr_ptr;
        scan_cand  = '0;
        for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
            scan_cand = rr_ptr + IDX_BITS'(i);
            if (!scan_found &&
                (consumer_read_valid[scan_cand] || consumer_write_valid[scan_cand])) begin
                scan_found = 1'b1;
                scan_idx   = scan_cand;
            end
        end
    end

    // Next-state and next-output logic; every registered output holds by default.
    always_comb begin : next_logic
        state_d             = state;
        rr_ptr_d            = rr_ptr;
        grant_id_d          = grant_id;
        mem_read_valid_d    = mem_read_valid;
        mem_read_address_d  = mem_read_address;
        mem_write_valid_d   = mem_write_valid;
        mem_write_address_d = mem_write_address;
        mem_write_data_d    = mem_write_data;
        read_ready_d        = consumer_read_ready;
        write_ready_d       = consumer_write_ready;
        read_data_d         = consumer_read_data;

        case (state)
            IDLE: begin
                if (scan_found) begin
                    grant_id_d = scan_idx;
                    // Truncation to IDX_BITS wraps NUM_CONSUMERS-1 back to 0.
                    rr_ptr_d   = scan_idx + IDX_BITS'(1);
                    // Read wins over a simultaneous write from the same consumer.
                    if (consumer_read_valid[scan_idx]) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = consumer_read_address[scan_idx];
                        state_d            = READ_WAITING;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = consumer_write_address[scan_idx];
                        mem_write_data_d    = consumer_write_data[scan_idx];
                        state_d             = WRITE_WAITING;
                    end
                end
            end

            READ_WAITING: begin
                if (mem_read_ready) begin
                    mem_read_valid_d        = 1'b0;
                    read_data_d[grant_id]   = mem_read_data;
                    read_ready_d[grant_id]  = 1'b1;
                    state_d                 = READ_RELAYING;
                end
            end

            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    mem_write_valid_d       = 1'b0;
                    write_ready_d[grant_id] = 1'b1;
                    state_d                 = WRITE_RELAYING;
                end
            end

            // Ready is held until the consumer drops its matching valid.
            READ_RELAYING: begin
                if (!consumer_read_valid[grant_id]) begin
                    read_ready_d[grant_id] = 1'b0;
                    state_d                = IDLE;
                end
            end

            WRITE_RELAYING: begin
                if (!consumer_write_valid[grant_id]) begin
                    write_ready_d[grant_id] = 1'b0;
                    state_d                 = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            grant_id             <= '0;
            busy                 <= 1'b0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            for (int i = 0; i < int'(NUM_CONSUMERS); i++) begin
                consumer_read_data[i] <= '0;
            end
        end else begin
            state                <= state_d;
            rr_ptr               <= rr_ptr_d;
            grant_id             <= grant_id_d;
            busy                 <= busy_d;
            mem_read_valid       <= mem_read_valid_d;
            mem_read_address     <= mem_read_address_d;
            mem_write_valid      <= mem_write_valid_d;
            mem_write_address    <= mem_write_address_d;
            mem_write_data       <= mem_write_data_d;
            consumer_read_ready  <= read_ready_d;
            consumer_write_ready <= write_ready_d;
            for (int i = 0; i < int'(NUM_CONSUMERS); i++) begin
                consumer_read_data[i] <= read_data_d[i];
            end
        end
    end

endmodule
